// File: rtl/pq_sched.sv
// pq_sched: operation scheduler for the AnTiQ array priority queue.
// Arbitrates push/pop/drop requests from NR requesters, issues one operation
// at a time into cell 0 of the pq_cell chain, enforces the post-push gap,
// tracks occupancy and returns one response per accepted request.
// Build option: define PQ_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins
// arbitration; the default build uses round-robin arbitration.

package pq_pkg;
  localparam int unsigned CELL_TW = 16;
  localparam int unsigned CELL_IW = 4;

  typedef struct packed {
    logic [CELL_TW-1:0] data;
    logic [CELL_IW-1:0] id;
  } cell_t;
endpackage

module pq_sched #(
  parameter int unsigned TW      = pq_pkg::CELL_TW,
  parameter int unsigned IW      = pq_pkg::CELL_IW,
  parameter int unsigned NR      = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP     = 2,
  parameter int unsigned DROP_TO = 2 * DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR-1:0]                req_vld_i,
  output logic [NR-1:0]                req_rdy_o,
  input  logic [2*NR-1:0]              req_op_i,
  input  logic [NR*TW-1:0]             req_data_i,
  input  logic [NR*IW-1:0]             req_id_i,
  output logic [NR-1:0]                rsp_vld_o,
  output logic [TW-1:0]                rsp_data_o,
  output logic [IW-1:0]                rsp_id_o,
  output logic                         rsp_err_o,
  output logic                         push_o,
  output logic                         pop_o,
  output logic                         drop_o,
  output logic [TW-1:0]                drop_id_o,
  output pq_pkg::cell_t                push_struct_o,
  input  logic                         pop_vld_i,
  input  pq_pkg::cell_t                pop_struct_i,
  input  logic                         drop_vld_i,
  input  logic                         full_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned IXW = $clog2(NR);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned TMW = $clog2(DROP_TO + 1);
  localparam int unsigned GW  = $clog2(GAP + 2);

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_DROP = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_POP,
    S_WAIT_DROP,
    S_RESP,
    S_GAP
  } state_t;

  state_t          state;
  op_t             lat_op;
  logic [TW-1:0]   lat_data;
  logic [IW-1:0]   lat_id;
  logic [IXW-1:0]  lat_idx;
  logic [TMW-1:0]  timer;
  logic [GW-1:0]   gap_cnt;

  logic [1:0]      op_arr   [NR];
  logic [TW-1:0]   data_arr [NR];
  logic [IW-1:0]   id_arr   [NR];

  logic [IXW-1:0]  grant;
  logic [IXW-1:0]  cand;
  logic            found;
  op_t             g_op;
  logic [TW-1:0]   g_data;
  logic [IW-1:0]   g_id;
  logic            g_legal;

`ifndef PQ_SCHED_FIXED_PRIO_EN
  logic [IXW-1:0]  ptr;
`endif

  for (genvar g = 0; g < NR; g++) begin : g_split
    assign op_arr[g]   = req_op_i[2*g +: 2];
    assign data_arr[g] = req_data_i[TW*g +: TW];
    assign id_arr[g]   = req_id_i[IW*g +: IW];
  end

  assign empty_o       = (count_o == '0);
  assign full_o        = (count_o == CW'(DEPTH)) || full_i;
  assign push_struct_o = '{data: lat_data, id: lat_id};
  assign drop_id_o     = TW'(lat_id);

  // Pick the winning requester: first valid one scanning from the pointer
  // (or from index 0 in fixed-priority builds).
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NR; i++) begin
`ifdef PQ_SCHED_FIXED_PRIO_EN
      cand = IXW'(i);
`else
      cand = IXW'((32'(ptr) + i) % NR);
`endif
      if (!found && req_vld_i[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Fields of the granted request and its legality against current occupancy.
  always_comb begin
    g_op    = op_t'(op_arr[grant]);
    g_data  = data_arr[grant];
    g_id    = id_arr[grant];
    g_legal = 1'b0;
    case (g_op)
      OP_PUSH: g_legal = !full_o && (g_data != '0);
      OP_POP:  g_legal = !empty_o;
      OP_DROP: g_legal = 1'b1;
      default: g_legal = 1'b0;
    endcase
  end

  // Accept strobe must appear in the grant cycle, so it is decoded directly.
  always_comb begin
    req_rdy_o = '0;
    if (state == S_IDLE && |req_vld_i) req_rdy_o = NR'(1) << grant;
  end

  // Scheduler FSM with registered op pulses, responses and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      lat_op     <= OP_PUSH;
      lat_data   <= '0;
      lat_id     <= '0;
      lat_idx    <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      count_o    <= '0;
      push_o     <= 1'b0;
      pop_o      <= 1'b0;
      drop_o     <= 1'b0;
      rsp_vld_o  <= '0;
      rsp_err_o  <= 1'b0;
      rsp_data_o <= '0;
      rsp_id_o   <= '0;
`ifndef PQ_SCHED_FIXED_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      push_o <= 1'b0;
      pop_o  <= 1'b0;
      drop_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_vld_i) begin
            lat_op   <= g_op;
            lat_data <= g_data;
            lat_id   <= g_id;
            lat_idx  <= grant;
`ifndef PQ_SCHED_FIXED_PRIO_EN
            ptr      <= (grant == IXW'(NR - 1)) ? '0 : grant + 1'b1;
`endif
            if (g_legal) begin
              push_o <= (g_op == OP_PUSH);
              pop_o  <= (g_op == OP_POP);
              drop_o <= (g_op == OP_DROP);
              state  <= S_ISSUE;
            end else begin
              rsp_vld_o <= NR'(1) << grant;
              rsp_err_o <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          case (lat_op)
            OP_PUSH: begin
              if (count_o != CW'(DEPTH)) count_o <= count_o + 1'b1;
              rsp_vld_o <= NR'(1) << lat_idx;
              rsp_err_o <= 1'b0;
              state     <= S_RESP;
            end
            OP_POP:  state <= S_WAIT_POP;
            OP_DROP: begin
              timer <= TMW'(DROP_TO);
              state <= S_WAIT_DROP;
            end
            default: begin
              rsp_vld_o <= NR'(1) << lat_idx;
              rsp_err_o <= 1'b1;
              state     <= S_RESP;
            end
          endcase
        end
        S_WAIT_POP: begin
          if (pop_vld_i) begin
            rsp_data_o <= pop_struct_i.data;
            rsp_id_o   <= pop_struct_i.id;
            if (count_o != '0) count_o <= count_o - 1'b1;
            rsp_vld_o  <= NR'(1) << lat_idx;
            rsp_err_o  <= 1'b0;
            state      <= S_RESP;
          end
        end
        S_WAIT_DROP: begin
          // The final timer tick lands the miss response exactly DROP_TO
          // cycles after entering this state.
          if (drop_vld_i) begin
            if (count_o != '0) count_o <= count_o - 1'b1;
            rsp_vld_o <= NR'(1) << lat_idx;
            rsp_err_o <= 1'b0;
            state     <= S_RESP;
          end else if (timer <= TMW'(1)) begin
            rsp_vld_o <= NR'(1) << lat_idx;
            rsp_err_o <= 1'b1;
            state     <= S_RESP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_RESP: begin
          rsp_vld_o  <= '0;
          rsp_err_o  <= 1'b0;
          rsp_data_o <= '0;
          rsp_id_o   <= '0;
          if (lat_op == OP_PUSH && !rsp_err_o && GAP != 0) begin
            gap_cnt <= GW'(GAP);
            state   <= S_GAP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_sched.sv
// Directed bench for pq_sched: table of single-request transactions with a
// tiny cell-0 responder, plus hand-written gap, reset and arbitration sequences.
module tb_pq_sched;
  localparam int unsigned TW      = 16;
  localparam int unsigned IW      = 4;
  localparam int unsigned NR      = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned GAP     = 2;
  localparam int unsigned DROP_TO = 16;

  localparam logic [1:0] PUSH = 2'b00;
  localparam logic [1:0] POP  = 2'b01;
  localparam logic [1:0] DROP = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [NR-1:0]      req_vld_i, req_rdy_o, rsp_vld_o;
  logic [1:0]         op_a   [NR];
  logic [TW-1:0]      data_a [NR];
  logic [IW-1:0]      id_a   [NR];
  logic [2*NR-1:0]    req_op_i;
  logic [NR*TW-1:0]   req_data_i;
  logic [NR*IW-1:0]   req_id_i;
  logic [TW-1:0]      rsp_data_o, drop_id_o;
  logic [IW-1:0]      rsp_id_o;
  logic               rsp_err_o, push_o, pop_o, drop_o;
  pq_pkg::cell_t      push_struct_o, pop_struct_i;
  logic               pop_vld_i, drop_vld_i, full_i;
  logic [3:0]         count_o;
  logic               empty_o, full_o;

  assign req_op_i   = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_data_i = {data_a[3], data_a[2], data_a[1], data_a[0]};
  assign req_id_i   = {id_a[3], id_a[2], id_a[1], id_a[0]};

  pq_sched #(.TW(TW), .IW(IW), .NR(NR), .DEPTH(DEPTH), .GAP(GAP), .DROP_TO(DROP_TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
    .req_data_i(req_data_i), .req_id_i(req_id_i),
    .rsp_vld_o(rsp_vld_o), .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
    .push_o(push_o), .pop_o(pop_o), .drop_o(drop_o), .drop_id_o(drop_id_o),
    .push_struct_o(push_struct_o), .pop_vld_i(pop_vld_i), .pop_struct_i(pop_struct_i),
    .drop_vld_i(drop_vld_i), .full_i(full_i),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned r;
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  id;
    int unsigned dly;    // cycles after the op pulse that cell 0 answers (0 = never)
    logic [15:0] cdata;
    logic [3:0]  cid;
    int unsigned pulse;  // 0 none, 1 push, 2 pop, 3 drop
    logic        err;
    logic [15:0] rdata;
    logic [3:0]  rid;
    int unsigned lat;    // response cycle relative to grant
    int unsigned cnt;    // occupancy after the response
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input int unsigned r, input logic [1:0] op, input logic [15:0] d,
                              input logic [3:0] id, input int unsigned dly, input logic [15:0] cd,
                              input logic [3:0] ci, input int unsigned pulse, input logic err,
                              input logic [15:0] rd, input logic [3:0] ri, input int unsigned lat,
                              input int unsigned cnt);
    vec_t v;
    v.r = r; v.op = op; v.data = d; v.id = id; v.dly = dly; v.cdata = cd; v.cid = ci;
    v.pulse = pulse; v.err = err; v.rdata = rd; v.rid = ri; v.lat = lat; v.cnt = cnt;
    return v;
  endfunction

  task automatic run_vec(input int k, input vec_t v);
    int unsigned   n, c, pulse_c, pulse_t, npulse;
    pq_pkg::cell_t pstruct;
    logic [15:0]   pdrop;
    logic [NR-1:0] oh, rv;
    bit            got;
    oh = NR'(1) << v.r;
    op_a[v.r] = v.op; data_a[v.r] = v.data; id_a[v.r] = v.id;
    req_vld_i = oh;
    #1;
    n = 0;
    while (req_rdy_o !== oh && n < 20) begin tick(); n++; end
    chk($sformatf("v%0d rdy", k), 32'(req_rdy_o), 32'(oh));
    tick();
    req_vld_i = '0;
    c = 1; npulse = 0; pulse_t = 0; pulse_c = 0; got = 0;
    pstruct = '0; pdrop = '0; rv = '0;
    while (!got && c <= 40) begin
      if (push_o || pop_o || drop_o) begin
        npulse++;
        pulse_t = push_o ? 1 : (pop_o ? 2 : 3);
        pulse_c = c;
        pstruct = push_struct_o;
        pdrop   = drop_id_o;
      end
      pop_vld_i = 1'b0; drop_vld_i = 1'b0;
      if (pulse_c != 0 && v.dly != 0 && c == pulse_c + v.dly) begin
        if (v.op == POP) begin
          pop_vld_i = 1'b1;
          pop_struct_i = '{data: v.cdata, id: v.cid};
        end else begin
          drop_vld_i = 1'b1;
        end
      end
      if (rsp_vld_o != '0) begin
        got = 1; rv = rsp_vld_o;
      end else begin
        tick(); c++;
      end
    end
    pop_vld_i = 1'b0; drop_vld_i = 1'b0;
    chk($sformatf("v%0d rsp_seen", k), 32'(got), 32'd1);
    chk($sformatf("v%0d rsp_cycle", k), c, v.lat);
    chk($sformatf("v%0d rsp_vld", k), 32'(rv), 32'(oh));
    chk($sformatf("v%0d rsp_err", k), 32'(rsp_err_o), 32'(v.err));
    chk($sformatf("v%0d rsp_data", k), 32'(rsp_data_o), 32'(v.rdata));
    chk($sformatf("v%0d rsp_id", k), 32'(rsp_id_o), 32'(v.rid));
    chk($sformatf("v%0d pulse_kind", k), pulse_t, v.pulse);
    chk($sformatf("v%0d pulse_num", k), npulse, (v.pulse != 0) ? 1 : 0);
    if (v.pulse != 0) chk($sformatf("v%0d pulse_cycle", k), pulse_c, 1);
    if (v.pulse == 1) chk($sformatf("v%0d push_struct", k), 32'(pstruct), {12'd0, v.data, v.id});
    if (v.pulse == 3) chk($sformatf("v%0d drop_id", k), 32'(pdrop), 32'(v.id));
    tick();
    chk($sformatf("v%0d rsp_clear", k), 32'(rsp_vld_o), 32'd0);
    chk($sformatf("v%0d count", k), 32'(count_o), v.cnt);
    chk($sformatf("v%0d empty", k), 32'(empty_o), 32'(v.cnt == 0));
    chk($sformatf("v%0d full", k), 32'(full_o), 32'((v.cnt == DEPTH) || full_i));
  endtask

  // Bounded wait for any response, then compare it.
  task automatic wait_rsp(input string nm, input logic [NR-1:0] exp_vld, input logic exp_err);
    int unsigned n;
    n = 0;
    while (rsp_vld_o == '0 && n < 40) begin tick(); n++; end
    chk({nm, " rsp_vld"}, 32'(rsp_vld_o), 32'(exp_vld));
    chk({nm, " rsp_err"}, 32'(rsp_err_o), 32'(exp_err));
    tick();
  endtask

  task automatic do_reset();
    req_vld_i = '0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [NR-1:0] exp_g;
    for (int i = 0; i < NR; i++) begin op_a[i] = '0; data_a[i] = '0; id_a[i] = '0; end
    req_vld_i = '0; pop_vld_i = 1'b0; drop_vld_i = 1'b0; full_i = 1'b0; pop_struct_i = '0;

    vecs[0]  = mk(0, PUSH, 16'd5, 4'd1, 0, 0, 0, 1, 1'b0, 0, 0, 2, 1);
    vecs[1]  = mk(2, POP,  16'd0, 4'd0, 2, 16'd5, 4'd1, 2, 1'b0, 16'd5, 4'd1, 4, 0);
    vecs[2]  = mk(1, POP,  16'd0, 4'd0, 0, 0, 0, 0, 1'b1, 0, 0, 1, 0);
    vecs[3]  = mk(3, PUSH, 16'd0, 4'd6, 0, 0, 0, 0, 1'b1, 0, 0, 1, 0);
    vecs[4]  = mk(1, RSVD, 16'd9, 4'd9, 0, 0, 0, 0, 1'b1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      vecs[5+i] = mk(i % 4, PUSH, 16'(100 + i), 4'(i), 0, 0, 0, 1, 1'b0, 0, 0, 2, i + 1);
    vecs[13] = mk(1, PUSH, 16'd50, 4'd9, 0, 0, 0, 0, 1'b1, 0, 0, 1, 8);
    vecs[14] = mk(2, DROP, 16'd0, 4'd3, 2, 0, 0, 3, 1'b0, 0, 0, 4, 7);
    vecs[15] = mk(1, DROP, 16'd0, 4'd9, 0, 0, 0, 3, 1'b1, 0, 0, 2 + DROP_TO, 7);
    vecs[16] = mk(0, POP,  16'd0, 4'd0, 1, 16'd10, 4'd0, 2, 1'b0, 16'd10, 4'd0, 3, 6);

    // Reset values
    do_reset();
    chk("reset push_o", 32'(push_o), 0);
    chk("reset pop_o", 32'(pop_o), 0);
    chk("reset drop_o", 32'(drop_o), 0);
    chk("reset rsp_vld", 32'(rsp_vld_o), 0);
    chk("reset rsp_err", 32'(rsp_err_o), 0);
    chk("reset count", 32'(count_o), 0);
    chk("reset empty", 32'(empty_o), 1);
    chk("reset full", 32'(full_o), 0);

    for (int k = 0; k < 17; k++) run_vec(k, vecs[k]);

    // Next grant after a push waits out GAP (count 6 -> 8)
    op_a[0] = PUSH; data_a[0] = 16'd7; id_a[0] = 4'd2; req_vld_i = 4'b0001;
    #1; n = 0;
    while (req_rdy_o !== 4'b0001 && n < 20) begin tick(); n++; end
    chk("gap first grant", 32'(req_rdy_o), 32'b0001);
    tick();
    op_a[1] = PUSH; data_a[1] = 16'd8; id_a[1] = 4'd4; req_vld_i = 4'b0010;
    #1; n = 1;
    while (req_rdy_o !== 4'b0010 && n < 20) begin tick(); n++; end
    chk("gap next grant cycle", n, 3 + GAP);
    tick(); req_vld_i = '0;
    wait_rsp("gap push", 4'b0010, 1'b0);
    chk("gap count", 32'(count_o), 8);

    // Next grant after an illegal request comes two cycles after the first
    op_a[0] = RSVD; req_vld_i = 4'b0001;
    #1; n = 0;
    while (req_rdy_o !== 4'b0001 && n < 20) begin tick(); n++; end
    chk("illegal first grant", 32'(req_rdy_o), 32'b0001);
    tick();
    chk("illegal rsp at T+1", 32'(rsp_vld_o), 32'b0001);
    chk("illegal err", 32'(rsp_err_o), 1);
    op_a[1] = RSVD; req_vld_i = 4'b0010;
    #1; n = 1;
    while (req_rdy_o !== 4'b0010 && n < 20) begin tick(); n++; end
    chk("illegal next grant cycle", n, 2);
    tick(); req_vld_i = '0;
    wait_rsp("illegal second", 4'b0010, 1'b1);

    // Reset while waiting for pop data
    op_a[2] = POP; req_vld_i = 4'b0100;
    #1; n = 0;
    while (req_rdy_o !== 4'b0100 && n < 20) begin tick(); n++; end
    chk("rstpop grant", 32'(req_rdy_o), 32'b0100);
    tick(); req_vld_i = '0;
    chk("rstpop pop_o", 32'(pop_o), 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstpop pop_o clear", 32'(pop_o), 0);
    chk("rstpop rsp_vld", 32'(rsp_vld_o), 0);
    chk("rstpop count", 32'(count_o), 0);
    chk("rstpop empty", 32'(empty_o), 1);
    chk("rstpop rsp_data", 32'(rsp_data_o), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstpop no rsp", 32'(rsp_vld_o), 0);
    end

    // External full with zero count rejects a push and leaves the count alone
    full_i = 1'b1;
    run_vec(17, mk(0, PUSH, 16'd5, 4'd1, 0, 0, 0, 0, 1'b1, 0, 0, 1, 0));
    full_i = 1'b0;

    // Arbitration with every requester valid
    do_reset();
    for (int i = 0; i < NR; i++) op_a[i] = RSVD;
    req_vld_i = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_rdy_o == '0 && n < 10) begin tick(); n++; end
`ifdef PQ_SCHED_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = NR'(1) << (k % 4);
`endif
      chk($sformatf("arb grant%0d", k), 32'(req_rdy_o), 32'(exp_g));
      tick();
    end
    req_vld_i = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
